csr_sequencer: RTL and testbench

Multi-cycle controller in front of the machine-mode CSR file. It owns the CSR file's address, read, write, write_type, trap and trap-cause inputs, and the shared 32-bit CSR bus. It turns one CSR instruction, trap entry or MRET request from the core into a sequence of single-cycle CSR-file operations. It returns the old CSR value for rd, the redirect PC (mtvec or mepc), and an illegal-instruction flag when the CSR file reports an unknown address.

---
 rtl/csr_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_csr_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_sequencer.sv
// Multi-cycle sequencer between the core and the machine-mode CSR file: breaks CSR
// instructions, trap entry and MRET into single-cycle CSR-file reads, writes and trap saves.
module csr_sequencer #(
    parameter logic [11:0] MTVEC_ADDR = 12'h305,
    parameter logic [11:0] MEPC_ADDR  = 12'h341
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [11:0] csr_num_i,
    input  logic [31:0] src_i,
    input  logic [4:0]  zimm_i,
    input  logic        rd_zero_i,
    input  logic        rs1_zero_i,
    input  logic        trap_req_i,
    input  logic [4:0]  trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic        mret_req_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        rd_we_o,
    output logic [31:0] rd_data_o,
    output logic        illegal_o,
    output logic        pc_load_o,
    output logic [31:0] new_pc_o,
    output logic [11:0] csr_addr_o,
    output logic        csr_read_o,
    output logic        csr_write_o,
    output logic [1:0]  csr_wtype_o,
    output logic        csr_trap_o,
    output logic [4:0]  csr_cause_o,
    inout  wire  [31:0] csr_bus_io,
    input  logic        csr_invalid_i
);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StTrapSave,
        StTrapVec,
        StMretRd,
        StFin
    } state_e;

    state_e      state_q, state_d;
    logic [11:0] addr_q, addr_d;
    logic [1:0]  wtype_q, wtype_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] trap_pc_q, trap_pc_d;
    logic [4:0]  cause_q, cause_d;
    logic        rs1_zero_q, rs1_zero_d;
    logic        rd_we_q, rd_we_d;
    logic        illegal_q, illegal_d;
    logic        pc_load_q, pc_load_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] new_pc_q, new_pc_d;

    logic        bus_oe;
    logic [31:0] bus_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wtype_q    <= '0;
            wdata_q    <= '0;
            trap_pc_q  <= '0;
            cause_q    <= '0;
            rs1_zero_q <= 1'b0;
            rd_we_q    <= 1'b0;
            illegal_q  <= 1'b0;
            pc_load_q  <= 1'b0;
            rd_data_q  <= '0;
            new_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wtype_q    <= wtype_d;
            wdata_q    <= wdata_d;
            trap_pc_q  <= trap_pc_d;
            cause_q    <= cause_d;
            rs1_zero_q <= rs1_zero_d;
            rd_we_q    <= rd_we_d;
            illegal_q  <= illegal_d;
            pc_load_q  <= pc_load_d;
            rd_data_q  <= rd_data_d;
            new_pc_q   <= new_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wtype_d    = wtype_q;
        wdata_d    = wdata_q;
        trap_pc_d  = trap_pc_q;
        cause_d    = cause_q;
        rs1_zero_d = rs1_zero_q;
        rd_we_d    = rd_we_q;
        illegal_d  = illegal_q;
        pc_load_d  = pc_load_q;
        rd_data_d  = rd_data_q;
        new_pc_d   = new_pc_q;

        case (state_q)
            StIdle: begin
                if (trap_req_i) begin
                    state_d   = StTrapSave;
                    cause_d   = trap_cause_i;
                    trap_pc_d = trap_pc_i;
                    rd_we_d   = 1'b0;
                    illegal_d = 1'b0;
                    pc_load_d = 1'b1;
                end else if (mret_req_i) begin
                    state_d   = StMretRd;
                    rd_we_d   = 1'b0;
                    illegal_d = 1'b0;
                    pc_load_d = 1'b1;
                end else if (start_i) begin
                    addr_d     = csr_num_i;
                    wtype_d    = op_i[1:0];
                    wdata_d    = op_i[2] ? {27'b0, zimm_i} : src_i;
                    rs1_zero_d = rs1_zero_i;
                    pc_load_d  = 1'b0;
                    if (op_i[1:0] == 2'b00) begin
                        state_d   = StFin;
                        illegal_d = 1'b1;
                        rd_we_d   = 1'b0;
                    end else begin
                        illegal_d = 1'b0;
                        rd_we_d   = !rd_zero_i;
                        // A plain write to x0 skips the read so read side effects never fire.
                        state_d   = (op_i[1:0] == 2'b01 && rd_zero_i) ? StWrite : StRead;
                    end
                end
            end
            StRead: begin
                rd_data_d = csr_bus_io;
                if (csr_invalid_i) begin
                    state_d   = StFin;
                    illegal_d = 1'b1;
                    rd_we_d   = 1'b0;
                end else if (wtype_q != 2'b01 && rs1_zero_q) begin
                    state_d = StFin;
                end else begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (csr_invalid_i) begin
                    illegal_d = 1'b1;
                    rd_we_d   = 1'b0;
                end
                state_d = StFin;
            end
            StTrapSave: state_d = StTrapVec;
            StTrapVec: begin
                new_pc_d = csr_bus_io;
                state_d  = StFin;
            end
            StMretRd: begin
                new_pc_d = csr_bus_io;
                state_d  = StFin;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // CSR-file strobes are gated by rst so an access in the reset cycle is never issued.
    always_comb begin
        csr_read_o  = 1'b0;
        csr_write_o = 1'b0;
        csr_trap_o  = 1'b0;
        csr_addr_o  = '0;
        csr_wtype_o = '0;
        csr_cause_o = '0;
        bus_oe      = 1'b0;
        bus_out     = '0;

        case (state_q)
            StRead: begin
                csr_read_o = !rst;
                csr_addr_o = addr_q;
            end
            StWrite: begin
                csr_write_o = !rst;
                csr_addr_o  = addr_q;
                csr_wtype_o = wtype_q;
                bus_oe      = !rst;
                bus_out     = wdata_q;
            end
            StTrapSave: begin
                csr_trap_o  = !rst;
                csr_cause_o = cause_q;
                bus_oe      = !rst;
                bus_out     = trap_pc_q;
            end
            StTrapVec: begin
                csr_read_o = !rst;
                csr_addr_o = MTVEC_ADDR;
            end
            StMretRd: begin
                csr_read_o = !rst;
                csr_addr_o = MEPC_ADDR;
            end
            default: ;
        endcase
    end

    assign csr_bus_io = bus_oe ? bus_out : 32'hzzzz_zzzz;

    assign busy_o    = (state_q != StIdle);
    assign done_o    = (state_q == StFin) && !rst;
    assign rd_we_o   = done_o && rd_we_q;
    assign illegal_o = done_o && illegal_q;
    assign pc_load_o = done_o && pc_load_q;
    assign rd_data_o = rd_data_q;
    assign new_pc_o  = new_pc_q;

endmodule

// File: tb/tb_csr_sequencer.sv
// Bench for csr_sequencer: a small CSR-file model on the shared bus plus a per-transaction
// reference model that predicts latency, result flags, returned values and CSR contents.
module tb_csr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [11:0] csr_num = '0;
    logic [31:0] src = '0;
    logic [4:0]  zimm = '0;
    logic        rd_zero = 1'b0;
    logic        rs1_zero = 1'b0;
    logic        trap_req = 1'b0;
    logic [4:0]  trap_cause = '0;
    logic [31:0] trap_pc = '0;
    logic        mret_req = 1'b0;
    logic        busy, done, rd_we, illegal, pc_load;
    logic [31:0] rd_data, new_pc;
    logic [11:0] csr_addr;
    logic        csr_read, csr_write, csr_trap;
    logic [1:0]  csr_wtype;
    logic [4:0]  csr_cause;
    wire  [31:0] csr_bus;
    logic        csr_invalid;

    localparam logic [31:0] Probe = 32'hA5C3_5A3C;

    int n_checks = 0;
    int n_fail   = 0;

    // CSR-file model state (written only by its own always block)
    logic [31:0] mem [0:4095];
    logic        poke_en = 1'b0;
    logic [11:0] poke_addr = '0;
    logic [31:0] poke_val = '0;
    // Drives a known pattern when nobody should be on the bus, exposing stray DUT drive.
    logic        probe_en = 1'b0;

    // Reference copy of CSR contents
    logic [31:0] ref_mem [0:4095];
    logic [11:0] addr_tab [6] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h7C0};

    always #5 clk = ~clk;

    csr_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .op_i         (op),
        .csr_num_i    (csr_num),
        .src_i        (src),
        .zimm_i       (zimm),
        .rd_zero_i    (rd_zero),
        .rs1_zero_i   (rs1_zero),
        .trap_req_i   (trap_req),
        .trap_cause_i (trap_cause),
        .trap_pc_i    (trap_pc),
        .mret_req_i   (mret_req),
        .busy_o       (busy),
        .done_o       (done),
        .rd_we_o      (rd_we),
        .rd_data_o    (rd_data),
        .illegal_o    (illegal),
        .pc_load_o    (pc_load),
        .new_pc_o     (new_pc),
        .csr_addr_o   (csr_addr),
        .csr_read_o   (csr_read),
        .csr_write_o  (csr_write),
        .csr_wtype_o  (csr_wtype),
        .csr_trap_o   (csr_trap),
        .csr_cause_o  (csr_cause),
        .csr_bus_io   (csr_bus),
        .csr_invalid_i(csr_invalid)
    );

    function automatic bit is_valid(input logic [11:0] a);
        return (a == 12'h300) || (a == 12'h305) || (a == 12'h340) ||
               (a == 12'h341) || (a == 12'h342);
    endfunction

    assign csr_invalid = (csr_read || csr_write) && !is_valid(csr_addr);
    assign csr_bus = (csr_read && is_valid(csr_addr)) ? mem[csr_addr] :
                     (probe_en ? Probe : 32'hzzzz_zzzz);

    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_val;
        end else if (csr_write && is_valid(csr_addr)) begin
            case (csr_wtype)
                2'b01:   mem[csr_addr] <= csr_bus;
                2'b10:   mem[csr_addr] <= mem[csr_addr] | csr_bus;
                2'b11:   mem[csr_addr] <= mem[csr_addr] & ~csr_bus;
                default: ;
            endcase
        end else if (csr_trap) begin
            mem[12'h341] <= csr_bus;
            mem[12'h342] <= {27'b0, csr_cause};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [31:0] v);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_val  = v;
        ref_mem[a] = v;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
    endtask

    // Issue one request (called #1 after a posedge with the DUT idle) and check it to completion.
    task automatic do_txn(input bit st, input bit tr, input bit mr, input logic [2:0] f3,
                          input logic [11:0] a, input logic [31:0] s, input logic [4:0] z,
                          input bit rdz, input bit rs1z, input logic [4:0] cause,
                          input logic [31:0] pc);
        int          exp_lat = 1, exp_rd = 0, exp_wr = 0, exp_tr = 0;
        bit          e_rdwe = 0, e_ill = 0, e_pcl = 0;
        logic [31:0] e_rd = '0, e_pc = '0, wd, old;
        int          cyc = 0, rd_cnt = 0, wr_cnt = 0, tr_cnt = 0;
        bit          got = 0, bad_busy = 0, bad_excl = 0;
        logic        o_rdwe = 0, o_ill = 0, o_pcl = 0;
        logic [31:0] o_rd = '0, o_pc = '0;
        logic [1:0]  o_wtype = '0;

        // Reference prediction from the architectural rules
        if (tr) begin
            exp_lat = 3; exp_rd = 1; exp_tr = 1; e_pcl = 1;
            e_pc = ref_mem[12'h305];
            ref_mem[12'h341] = pc;
            ref_mem[12'h342] = {27'b0, cause};
        end else if (mr) begin
            exp_lat = 2; exp_rd = 1; e_pcl = 1;
            e_pc = ref_mem[12'h341];
        end else if (f3[1:0] == 2'b00) begin
            exp_lat = 1; e_ill = 1;
        end else begin
            wd  = f3[2] ? {27'b0, z} : s;
            old = ref_mem[a];
            if (f3[1:0] == 2'b01 && rdz) begin
                exp_lat = 2; exp_wr = 1;
                if (!is_valid(a)) e_ill = 1;
                else ref_mem[a] = wd;
            end else begin
                exp_rd = 1;
                if (!is_valid(a)) begin
                    exp_lat = 2; e_ill = 1;
                end else begin
                    e_rdwe = !rdz;
                    e_rd   = old;
                    if (f3[1:0] != 2'b01 && rs1z) begin
                        exp_lat = 2;
                    end else begin
                        exp_lat = 3; exp_wr = 1;
                        case (f3[1:0])
                            2'b01:   ref_mem[a] = wd;
                            2'b10:   ref_mem[a] = old | wd;
                            default: ref_mem[a] = old & ~wd;
                        endcase
                    end
                end
            end
        end

        start = st; trap_req = tr; mret_req = mr; op = f3; csr_num = a; src = s; zimm = z;
        rd_zero = rdz; rs1_zero = rs1z; trap_cause = cause; trap_pc = pc;
        @(posedge clk);
        #1;
        start = 0; trap_req = 0; mret_req = 0;

        while (!got && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (!busy) bad_busy = 1;
            if ((32'(csr_read) + 32'(csr_write) + 32'(csr_trap)) > 1) bad_excl = 1;
            if (csr_read) rd_cnt++;
            if (csr_trap) tr_cnt++;
            if (csr_write) begin
                wr_cnt++;
                o_wtype = csr_wtype;
            end
            if (done) begin
                got = 1;
                o_rdwe = rd_we; o_ill = illegal; o_pcl = pc_load; o_rd = rd_data; o_pc = new_pc;
            end
            @(posedge clk);
            #1;
        end

        check_eq("done_seen", 32'(got), 1);
        if (got) begin
            check_eq("latency", cyc, exp_lat);
            check_eq("rd_we", 32'(o_rdwe), 32'(e_rdwe));
            check_eq("illegal", 32'(o_ill), 32'(e_ill));
            check_eq("pc_load", 32'(o_pcl), 32'(e_pcl));
            if (e_rdwe) check_eq("rd_data", o_rd, e_rd);
            if (e_pcl) check_eq("new_pc", o_pc, e_pc);
        end
        check_eq("busy_during", 32'(bad_busy), 0);
        check_eq("strobe_excl", 32'(bad_excl), 0);
        check_eq("read_count", rd_cnt, exp_rd);
        check_eq("write_count", wr_cnt, exp_wr);
        check_eq("trap_count", tr_cnt, exp_tr);
        if (exp_wr != 0 && wr_cnt != 0) check_eq("wtype", 32'(o_wtype), 32'(f3[1:0]));
        check_eq("idle_after", 32'(busy), 0);
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("csr_%h", addr_tab[i]), mem[addr_tab[i]], ref_mem[addr_tab[i]]);
        end
    endtask

    initial begin
        // CSR contents are loaded while the sequencer is held in reset.
        #1;
        poke(12'h300, 32'h0);
        poke(12'h305, 32'h4);
        poke(12'h340, 32'h1234);
        poke(12'h341, 32'hFF);
        poke(12'h342, 32'h0);

        probe_en = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_pulses", {27'b0, done, rd_we, illegal, pc_load, 1'b0}, 0);
        check_eq("rst_strobes", {29'b0, csr_read, csr_write, csr_trap}, 0);
        check_eq("rst_addr", 32'(csr_addr), 0);
        check_eq("rst_wtype_cause", {25'b0, csr_wtype, csr_cause}, 0);
        check_eq("rst_rd_data", rd_data, 0);
        check_eq("rst_new_pc", new_pc, 0);
        check_eq("rst_bus", csr_bus, Probe);
        @(posedge clk);
        #1;
        rst = 1'b0;
        probe_en = 1'b0;

        // Directed scenarios
        do_txn(1, 0, 0, 3'b010, 12'h340, 32'h0, 5'd0, 0, 1, 5'd0, 32'h0);        // CSRRS x0
        poke(12'h340, 32'h1);
        do_txn(1, 0, 0, 3'b001, 12'h340, 32'hDEADBEEF, 5'd0, 0, 0, 5'd0, 32'h0); // CSRRW
        do_txn(1, 0, 0, 3'b010, 12'h340, 32'h0, 5'd0, 0, 1, 5'd0, 32'h0);        // read back
        do_txn(1, 0, 0, 3'b111, 12'h341, 32'h0, 5'd5, 0, 0, 5'd0, 32'h0);        // CSRRCI mepc
        do_txn(1, 0, 0, 3'b001, 12'h7C0, 32'h9, 5'd0, 0, 0, 5'd0, 32'h0);        // unknown CSR
        do_txn(1, 0, 0, 3'b001, 12'h7C0, 32'h9, 5'd0, 1, 0, 5'd0, 32'h0);        // unknown, rd=x0
        do_txn(1, 0, 0, 3'b100, 12'h340, 32'h9, 5'd0, 0, 0, 5'd0, 32'h0);        // illegal op
        do_txn(1, 0, 0, 3'b101, 12'h300, 32'h0, 5'd9, 1, 0, 5'd0, 32'h0);        // CSRRWI x0
        do_txn(1, 1, 0, 3'b001, 12'h340, 32'h77, 5'd0, 0, 0, 5'd2, 32'h80);      // trap wins
        do_txn(0, 0, 1, 3'b000, 12'h000, 32'h0, 5'd0, 0, 0, 5'd0, 32'h0);        // MRET

        // Reset while the sequencer sits in WRITE
        start = 1; op = 3'b001; csr_num = 12'h340; src = 32'h55AA_66BB; rd_zero = 0;
        @(posedge clk);
        #1;
        start = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        probe_en = 1'b1;
        @(negedge clk);
        check_eq("rstw_write", 32'(csr_write), 0);
        check_eq("rstw_done", 32'(done), 0);
        check_eq("rstw_bus", csr_bus, Probe);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rstw_busy", 32'(busy), 0);
        check_eq("rstw_done2", 32'(done), 0);
        check_eq("rstw_bus2", csr_bus, Probe);
        check_eq("rstw_rd_data", rd_data, 0);
        check_eq("rstw_mem", mem[12'h340], ref_mem[12'h340]);
        @(posedge clk);
        #1;
        probe_en = 1'b0;
        do_txn(1, 0, 0, 3'b011, 12'h340, 32'h0000_00FF, 5'd0, 0, 0, 5'd0, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            bit          r_tr, r_mr, r_st;
            logic [2:0]  r_op;
            logic [11:0] r_a;
            r_tr = ($urandom_range(0, 7) == 0);
            r_mr = ($urandom_range(0, 7) == 0);
            r_st = ($urandom_range(0, 5) != 0) || !(r_tr || r_mr);
            r_op = 3'($urandom_range(0, 7));
            r_a  = addr_tab[$urandom_range(0, 5)];
            do_txn(r_st, r_tr, r_mr, r_op, r_a, $urandom, 5'($urandom_range(0, 31)),
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                   5'($urandom_range(0, 31)), $urandom & 32'hFFFF_FFFC);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
